// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared types and constants for the data-memory arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // Sliced down to the actual strobe width by the users (supports up to 512-bit words).
  localparam int unsigned   MAX_STRB_WIDTH = 64;
  localparam logic [MAX_STRB_WIDTH-1:0] STRB_FULL = '1;

endpackage

`default_nettype wire

// File: rtl/dmem_byte_merge.sv
// ---------------------------------------------------------------------------
// dmem_byte_merge : per-byte select between the stored word and new write data
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_byte_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic [DATA_WIDTH-1:0] merged
);

  for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_byte
    assign merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : round-robin sharing of a single-port data memory between the
//                core and debug ports, with read-modify-write for sub-word stores
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     n_clr,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  input  logic [STRB_WIDTH-1:0]    wstrb0,
  input  logic [STRB_WIDTH-1:0]    wstrb1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     busy,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam logic [STRB_WIDTH-1:0] STRB_ALL = STRB_FULL[STRB_WIDTH-1:0];

  state_t                   state_q;
  state_t                   state_d;
  logic                     rr_last;
  logic [ADDRESS_WIDTH-1:0] rmw_addr;
  logic [DATA_WIDTH-1:0]    rmw_data;

  logic                     sel;
  logic                     any_req;
  logic                     grant;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic [STRB_WIDTH-1:0]    sel_strb;
  logic                     do_rd;
  logic                     do_full_wr;
  logic                     do_rmw;
  logic [DATA_WIDTH-1:0]    merged;

  dmem_byte_merge #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH)
  ) u_merge (
    .old_word(mem_rdata),
    .new_word(sel_wdata),
    .strb    (sel_strb),
    .merged  (merged)
  );

  // Under contention the port that did not win last time goes first.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) sel = ~rr_last;
    else              sel = req1 ? PORT_DBG : PORT_CORE;

    sel_we    = (sel == PORT_DBG) ? we1    : we0;
    sel_addr  = (sel == PORT_DBG) ? addr1  : addr0;
    sel_wdata = (sel == PORT_DBG) ? wdata1 : wdata0;
    sel_strb  = (sel == PORT_DBG) ? wstrb1 : wstrb0;

    grant      = n_clr && (state_q == ST_IDLE) && any_req;
    gnt0       = grant && (sel == PORT_CORE);
    gnt1       = grant && (sel == PORT_DBG);
    do_rd      = grant && !sel_we;
    do_full_wr = grant && sel_we && (sel_strb == STRB_ALL);
    do_rmw     = grant && sel_we && (sel_strb != STRB_ALL) && (sel_strb != '0);
    busy       = (state_q == ST_RMW_WR);

    mem_we    = do_full_wr || (n_clr && state_q == ST_RMW_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) mem_addr = sel_addr;
        if (do_full_wr) mem_wdata = sel_wdata;
        if (do_rmw) state_d = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_addr  = rmw_addr;
        mem_wdata = rmw_data;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_clr) begin
      state_q  <= ST_IDLE;
      rr_last  <= 1'b1;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      rmw_addr <= '0;
      rmw_data <= '0;
    end else begin
      state_q <= state_d;
      rvalid0 <= do_rd && (sel == PORT_CORE);
      rvalid1 <= do_rd && (sel == PORT_DBG);
      if (do_rd && sel == PORT_CORE) rdata0 <= mem_rdata;
      if (do_rd && sel == PORT_DBG)  rdata1 <= mem_rdata;
      if (grant) rr_last <= sel;
      if (do_rmw) begin
        rmw_addr <= sel_addr;
        rmw_data <= merged;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed self-checking bench with a behavioural data_mem
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        n_clr;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  wstrb0, wstrb1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk(clk), .n_clr(n_clr),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wstrb0(wstrb0), .wstrb1(wstrb1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; wstrb0 = 0; wstrb1 = 0;
  endtask

  task automatic set0(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req0 = 1; we0 = we; addr0 = a; wdata0 = d; wstrb0 = s;
  endtask

  task automatic set1(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req1 = 1; we1 = we; addr1 = a; wdata1 = d; wstrb1 = s;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); n_clr = 0; set0(0, 32'd20, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 cyc%0d got=%b exp=0", c, gnt0); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we cyc%0d got=%b exp=0", c, mem_we); end
      @(negedge clk);
    end
    total++; if ({rvalid0, rvalid1} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b exp=00", {rvalid0, rvalid1}); end
    total++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
    idle_inputs(); n_clr = 1;
  endtask

  task automatic test_full_write_read();
    @(negedge clk); idle_inputs(); set0(1, 32'd20, 32'd10, 4'hF); #1;
    total++; if (gnt0 !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL fw_gnt_we got=%b%b exp=11", gnt0, mem_we); end
    total++; if (mem_addr !== 32'd20 || mem_wdata !== 32'd10) begin bad++; $display("FAIL fw_bus got=%0d/%0d exp=20/10", mem_addr, mem_wdata); end
    @(negedge clk); idle_inputs(); set0(0, 32'd20, 0, 4'hF); #1;
    total++; if (gnt0 !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_gnt_we got=%b%b exp=10", gnt0, mem_we); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (rvalid0 !== 1'b1 || rdata0 !== 32'd10) begin bad++; $display("FAIL rd_return got=%b/%h exp=1/0000000a", rvalid0, rdata0); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL idle_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    @(negedge clk); #1;
    total++; if (rvalid0 !== 1'b0 || rdata0 !== 32'd10) begin bad++; $display("FAIL rvalid_pulse got=%b/%h exp=0/0000000a", rvalid0, rdata0); end
  endtask

  task automatic test_partial_store();
    @(negedge clk); idle_inputs(); set0(1, 32'd0, 32'h11223344, 4'hF);
    @(negedge clk); idle_inputs(); set1(1, 32'd0, 32'h000000AB, 4'b0001); #1;
    total++; if (gnt1 !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ps_gnt got=%b%b%b exp=100", gnt1, mem_we, busy); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (busy !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL ps_rmw got=%b%b exp=11", busy, mem_we); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h112233AB) begin bad++; $display("FAIL ps_wdata got=%h/%h exp=0/112233ab", mem_addr, mem_wdata); end
    @(negedge clk); set1(0, 32'd0, 0, 0); #1;
    total++; if (gnt1 !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ps_rd_gnt got=%b%b exp=10", gnt1, busy); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h112233AB) begin bad++; $display("FAIL ps_rd got=%b/%h exp=1/112233ab", rvalid1, rdata1); end
  endtask

  task automatic test_contention();
    logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk); idle_inputs(); set0(1, 32'd25, 32'h00002525, 4'hF);
    @(negedge clk); idle_inputs(); n_clr = 0;
    @(negedge clk); n_clr = 1; set0(0, 32'd20, 0, 0); set1(0, 32'd25, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (gnt0 !== !exp_g[k] || gnt1 !== exp_g[k]) begin bad++; $display("FAIL cont_gnt cyc%0d got=%b%b exp=%b%b", k, gnt0, gnt1, !exp_g[k], exp_g[k]); end
      if (k > 0) begin
        total++;
        if (rvalid0 !== !exp_g[k-1] || rvalid1 !== exp_g[k-1] ||
            (!exp_g[k-1] && rdata0 !== 32'd10) || (exp_g[k-1] && rdata1 !== 32'h2525)) begin
          bad++; $display("FAIL cont_rv cyc%0d got=%b%b %h/%h", k, rvalid0, rvalid1, rdata0, rdata1);
        end
      end
      @(negedge clk);
    end
    idle_inputs(); #1;
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata1 !== 32'h2525) begin bad++; $display("FAIL cont_last got=%b%b/%h exp=01/00002525", rvalid0, rvalid1, rdata1); end
  endtask

  task automatic test_rmw_contention();
    @(negedge clk); idle_inputs(); set0(1, 32'd20, 32'h0000FF00, 4'b0010); #1;
    total++; if (gnt0 !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL rc_gnt0 got=%b%b exp=10", gnt0, mem_we); end
    @(negedge clk); idle_inputs(); set1(0, 32'd20, 0, 0); #1;
    total++; if (gnt1 !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h0000FF0A) begin
      bad++; $display("FAIL rc_rmw got=gnt%b busy%b we%b %h exp=0 1 1 0000ff0a", gnt1, busy, mem_we, mem_wdata);
    end
    @(negedge clk); #1;
    total++; if (gnt1 !== 1'b1 || mem_addr !== 32'd20) begin bad++; $display("FAIL rc_gnt1 got=%b/%0d exp=1/20", gnt1, mem_addr); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h0000FF0A) begin bad++; $display("FAIL rc_rd got=%b/%h exp=1/0000ff0a", rvalid1, rdata1); end
  endtask

  task automatic test_reset_mid_rmw();
    @(negedge clk); idle_inputs(); set0(1, 32'd25, 32'h00000077, 4'b0001); #1;
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL rm_gnt got=%b exp=1", gnt0); end
    @(negedge clk); idle_inputs(); n_clr = 0; #1;
    total++; if (mem_we !== 1'b0 || gnt0 !== 1'b0) begin bad++; $display("FAIL rm_we got=%b%b exp=00", mem_we, gnt0); end
    @(negedge clk); n_clr = 1; set0(0, 32'd25, 0, 0); #1;
    total++; if (busy !== 1'b0 || gnt0 !== 1'b1) begin bad++; $display("FAIL rm_idle got=%b%b exp=01", busy, gnt0); end
    @(negedge clk); idle_inputs(); set1(1, 32'd25, 32'hDEAD, 4'b0000); #1;
    total++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h2525) begin bad++; $display("FAIL rm_unchanged got=%b/%h exp=1/00002525", rvalid0, rdata0); end
    total++; if (gnt1 !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL zs_gnt got=%b%b exp=10", gnt1, mem_we); end
    @(negedge clk); idle_inputs(); set0(0, 32'd25, 0, 0); #1;
    total++; if (busy !== 1'b0 || mem_we !== 1'b0 || gnt0 !== 1'b1) begin bad++; $display("FAIL zs_noop got=%b%b%b exp=001", busy, mem_we, gnt0); end
    @(negedge clk); idle_inputs(); #1;
    total++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h2525) begin bad++; $display("FAIL zs_rd got=%b/%h exp=1/00002525", rvalid0, rdata0); end
  endtask

  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    idle_inputs();
    n_clr = 0;
    test_reset();
    test_full_write_read();
    test_partial_store();
    test_contention();
    test_rmw_contention();
    test_reset_mid_rmw();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
